// File: rtl/sort_engine_pkg.sv
// sort_engine_pkg: shared FSM state encoding and default sizes for sort_engine
package sort_engine_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sort_engine_cmp_swap.sv
// sort_cmp_swap: compare two elements and order them, swapping only on strict greater-than
// ports: a, b in; lo, hi ordered out; swapped high when a > b
// SORT_ENGINE_SIGNED_EN selects two's-complement compare, otherwise unsigned
module sort_cmp_swap
  import sort_engine_pkg::*;
#(
  parameter int W = DATA_W_DEF
)(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);
`ifdef SORT_ENGINE_SIGNED_EN
  assign swapped = $signed(a) > $signed(b);
`else
  assign swapped = a > b;
`endif
  assign lo = swapped ? b : a;
  assign hi = swapped ? a : b;
endmodule

// File: rtl/sort_engine.sv
// sort_engine: in-place bubble sort over a DEPTH-entry register array, one compare per cycle
// ports: clk, reset (async active-low); wr_en/wr_addr/wr_data load port (IDLE/DONE only);
//        start sort request; rd_addr/rd_data combinational read; busy in RUN; done one-cycle pulse;
//        swap_count swaps of current/last sort (saturating)
// SORT_ENGINE_SIGNED_EN selects signed element ordering
module sort_engine
  import sort_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count
);
  state_t state;
  logic [DATA_W-1:0] elem [DEPTH];
  logic [AW-1:0] idx, limit, idx_nx;
  logic pass_swapped, swapped, pass_end;
  logic [DATA_W-1:0] lo, hi;
  assign idx_nx = idx + AW'(1);
  assign pass_end = idx == limit - AW'(1);
  assign rd_data = elem[rd_addr];
  sort_cmp_swap #(.W(DATA_W)) u_cmp (
    .a(elem[idx]),
    .b(elem[idx_nx]),
    .lo(lo),
    .hi(hi),
    .swapped(swapped)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      limit <= '0;
      pass_swapped <= 1'b0;
      swap_count <= '0;
      for (int i = 0; i < DEPTH; i++) elem[i] <= '0;
    end else if (state == RUN) begin
      if (swapped) begin
        elem[idx] <= lo;
        elem[idx_nx] <= hi;
        swap_count <= &swap_count ? swap_count : swap_count + CNT_W'(1);
      end
      // the swap decided this cycle counts toward the pass that is ending
      if (pass_end) begin
        if (!(pass_swapped || swapped) || limit == AW'(1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          limit <= limit - AW'(1);
          idx <= '0;
          pass_swapped <= 1'b0;
        end
      end else begin
        idx <= idx_nx;
        pass_swapped <= pass_swapped | swapped;
      end
    end else begin
      if (wr_en) elem[wr_addr] <= wr_data;
      if (state == DONE) begin
        state <= IDLE;
        done <= 1'b0;
      end else if (start) begin
        state <= RUN;
        busy <= 1'b1;
        idx <= '0;
        limit <= AW'(DEPTH - 1);
        pass_swapped <= 1'b0;
        swap_count <= '0;
      end
    end
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: randomized scoreboard bench for sort_engine against a rank/inversion reference model
module tb_sort_engine;
  typedef logic [7:0][63:0] arr_t;
  typedef struct {
    logic rst;
    arr_t arr;
    int   swaps;
    int   cycles;
  } exp_t;
  logic clk = 0, reset = 0;
  logic wr_en = 0, start = 0;
  logic [2:0] wr_addr = 0, rd_addr = 0;
  logic [63:0] wr_data = 0, rd_data;
  logic busy, done;
  logic [15:0] swap_count;
  logic wr1_en = 0, start1 = 0;
  logic wr1_addr = 0, rd1_addr = 0;
  logic [63:0] wr1_data = 0, rd1_data;
  logic busy1, done1;
  logic [15:0] sc1;
  exp_t sb[$];
  arr_t cur;
  int n_chk = 0, n_pass = 0, s_chk = 0, s_pass = 0, done_seen = 0;
  always #50 clk = ~clk;
  sort_engine #(.DATA_W(64), .DEPTH(8), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .swap_count(swap_count)
  );
  sort_engine #(.DATA_W(64), .DEPTH(2), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr1_en), .wr_addr(wr1_addr), .wr_data(wr1_data),
    .start(start1), .rd_addr(rd1_addr), .rd_data(rd1_data), .busy(busy1), .done(done1),
    .swap_count(sc1)
  );
  function automatic bit gt(logic [63:0] a, logic [63:0] b);
`ifdef SORT_ENGINE_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction
  // sorted position = stable rank; swaps = inversions; passes = max left-larger count + 1, capped at DEPTH-1
  function automatic exp_t model(arr_t a);
    exp_t e;
    int lmax, p;
    e.rst = 0; e.swaps = 0; e.cycles = 0; e.arr = '0; lmax = 0;
    for (int i = 0; i < 8; i++) begin
      int pos, left;
      pos = 0; left = 0;
      for (int j = 0; j < 8; j++) begin
        if (gt(a[i], a[j]) || (j < i && a[j] == a[i])) pos++;
        if (j < i && gt(a[j], a[i])) left++;
      end
      e.arr[pos] = a[i];
      e.swaps += left;
      if (left > lmax) lmax = left;
    end
    p = (lmax + 1 < 7) ? lmax + 1 : 7;
    for (int k = 0; k < p; k++) e.cycles += 7 - k;
    return e;
  endfunction
  function automatic void chk(string n, logic [63:0] act, logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", n, act, want);
  endfunction
  function automatic void chk_s(string n, logic [63:0] act, logic [63:0] want);
    s_chk++;
    if (act === want) s_pass++;
    else $display("FAIL %s got=%0h want=%0h", n, act, want);
  endfunction
  initial begin : monitor
    exp_t e;
    int run_cyc;
    run_cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        run_cyc = 0;
        if (sb.size() > 0 && sb[0].rst) begin
          e = sb.pop_front();
          chk("rst_busy", 64'(busy), 0);
          chk("rst_done", 64'(done), 0);
          chk("rst_swap_count", 64'(swap_count), 0);
          for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #2;
            chk($sformatf("rst_elem%0d", i), rd_data, 0);
          end
        end
      end else begin
        if (busy) run_cyc++;
        if (done) begin
          if (sb.size() == 0 || sb[0].rst) chk("unexpected_done", 64'(done), 0);
          else begin
            e = sb.pop_front();
            chk("swap_count", 64'(swap_count), 64'(e.swaps));
            chk("run_cycles", 64'(run_cyc), 64'(e.cycles));
            for (int i = 0; i < 8; i++) begin
              rd_addr = 3'(i);
              #2;
              chk($sformatf("elem%0d", i), rd_data, e.arr[i]);
            end
          end
          done_seen++;
          run_cyc = 0;
        end
      end
    end
  end
  task automatic load(arr_t a);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = a[i];
      @(negedge clk);
    end
    wr_en = 0;
    cur = a;
  endtask
  task automatic wait_done(int base);
    for (int k = 0; k < 200 && done_seen == base; k++) @(negedge clk);
    chk_s("done_timeout", 64'(done_seen != base), 1);
    @(negedge clk);
  endtask
  task automatic go(bit wr0, bit disturb);
    exp_t e;
    int base;
    if (wr0) cur[0] = 64'd9;
    e = model(cur);
    sb.push_back(e);
    base = done_seen;
    wr_en = wr0; wr_addr = 0; wr_data = 64'd9; start = 1;
    @(negedge clk);
    wr_en = 0; start = 0;
    if (disturb) begin
      @(negedge clk);
      wr_en = 1; wr_addr = 3'd3; wr_data = 64'hdead; start = 1;
      @(negedge clk);
      wr_en = 0; start = 0;
    end
    wait_done(base);
  endtask
  initial begin : stim
    arr_t a;
    exp_t r;
    r.rst = 1; r.arr = '0; r.swaps = 0; r.cycles = 0;
    sb.push_back(r);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) a[i] = 64'(i + 1);
    load(a); go(0, 0);
    for (int i = 0; i < 8; i++) a[i] = 64'(8 - i);
    load(a); go(0, 0);
    a = '0;
    a[0] = 5; a[1] = 5; a[2] = 2; a[3] = 7; a[4] = 2; a[5] = 0; a[6] = 5; a[7] = 1;
    load(a); go(0, 0);
    for (int i = 0; i < 8; i++) a[i] = 64'(i + 1);
    load(a); go(1, 1);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++)
        a[i] = n[0] ? {$urandom, $urandom} : 64'($urandom_range(0, 7));
      load(a); go(0, 0);
    end
    for (int i = 0; i < 8; i++) a[i] = 64'(8 - i);
    load(a);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    sb.push_back(r);
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (40) @(negedge clk);
    wr1_en = 1; wr1_addr = 0; wr1_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    wr1_addr = 1; wr1_data = 64'd3;
    @(negedge clk);
    wr1_en = 0; start1 = 1;
    @(negedge clk);
    start1 = 0;
    for (int k = 0; k < 20 && !done1; k++) @(negedge clk);
    chk_s("d2_done", 64'(done1), 1);
`ifdef SORT_ENGINE_SIGNED_EN
    chk_s("d2_swap_count", 64'(sc1), 0);
    rd1_addr = 0; #1; chk_s("d2_elem0", rd1_data, 64'hFFFF_FFFF_FFFF_FFFF);
    rd1_addr = 1; #1; chk_s("d2_elem1", rd1_data, 64'd3);
`else
    chk_s("d2_swap_count", 64'(sc1), 1);
    rd1_addr = 0; #1; chk_s("d2_elem0", rd1_data, 64'd3);
    rd1_addr = 1; #1; chk_s("d2_elem1", rd1_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    repeat (5) @(negedge clk);
    chk_s("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass + s_pass, n_chk + s_chk);
    $finish;
  end
endmodule
